pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//   Parametrised elastic pipeline-register chain: DEPTH stages of WIDTH-bit payload,
//   each with a valid bit, backpressure (valid/ready) and per-stage flush.
//   Generalises the fixed IFID/IDEX/EXMM/MMWB latches of the mips core.
//   Used between core stages; flush inserts an all-zero bubble (NOP).
//   Also provides occupancy and saturating backpressure-stall counters.
// PARAMETERS
//   WIDTH  274  payload bits per stage
//   DEPTH  4    number of register stages (>=1)
//   CNT_W  16   stall counter width
// PORTS
//   clk        in   1              rising-edge clock
//   rst        in   1              asynchronous reset, active-high
//   in_valid   in   1              upstream payload valid
//   in_data    in   WIDTH          upstream payload
//   in_ready   out  1              chain accepts in_data this cycle
//   out_valid  out  1              stage DEPTH-1 holds valid payload
//   out_data   out  WIDTH          stage DEPTH-1 payload
//   out_ready  in   1              downstream consumes this cycle
//   flush      in   DEPTH          bit i: stage i becomes bubble at next edge
//   stall_clr  in   1              synchronous clear of stall_cnt
//   occupancy  out  $clog2(DEPTH+1) number of valid stages
//   stall_cnt  out  CNT_W          cycles with out_valid && !out_ready
// BEHAVIOUR
// - Reset (async, rst=1): all valid[i]=0, data[i]=0, stall_cnt=0.
//   Hence out_valid=0, out_data=0, occupancy=0, in_ready=1.
// - Readiness:
//   - rdy[DEPTH] = out_ready.
//   - rdy[i] = !valid[i] || rdy[i+1], combinational, from registered valid only.
//   - in_ready = rdy[0]; flush never affects any rdy[i].
// - Per edge, for each stage i (stage -1 = input port):
//   - if rdy[i]: valid[i] <= valid[i-1], data[i] <= data[i-1] (load or bubble).
//   - else: hold valid[i] and data[i] (stall).
//   - Bubble load (valid[i-1]=0) writes data[i] <= 0.
//   - if flush[i]: valid[i] <= 0, data[i] <= 0. Overrides both load and hold.
// - Flush kills the next contents of a stage only:
//   - The entry leaving stage i still advances into i+1 unless flush[i+1].
//   - A transfer accepted with flush[0]=1 completes the handshake (in_ready=1)
//     and the payload is discarded.
// - Latency: DEPTH cycles from input to output when never stalled.
//   Throughput is 1 per cycle when out_ready=1.
// - No payload is duplicated or lost absent flush.
//   out_data is stable while out_valid && !out_ready.
// - Input-side rules:
//   - in_data is ignored when in_valid=0.
//   - in_valid may drop without handshake; the chain never requires it held.
// - occupancy = popcount(valid), combinational from registers.
//   Range 0..DEPTH; in_ready=0 implies occupancy=DEPTH.
// - stall_cnt:
//   - +1 each edge with out_valid && !out_ready; saturates at all-ones.
//   - stall_clr=1 -> 0 at edge; clr wins over increment.
// - rst mid-stall or mid-flush: all state is lost immediately.
//   First post-reset edge behaves as from empty.
// TESTING
// - Reset with traffic:
//   Drive in_valid=1, out_ready=1, assert rst -> out_valid=0, occupancy=0,
//   in_ready=1, stall_cnt=0 immediately.
// - Streaming (DEPTH=4):
//   Push 0x1..0x8 back-to-back, out_ready=1 -> 0x1 on out_data at edge 4, then
//   one per cycle in order.
// - Full backpressure (DEPTH=4):
//   Push 6 items, out_ready=0 -> after 4 edges in_ready=0 and occupancy=4.
//   Items 5 and 6 are held by the source.
//   Release -> items 1..6 emerge in order; stall_cnt equals cycles stalled.
// - Flush mid-chain (DEPTH=4):
//   Stream A,B,C,D; at the edge where B would enter stage 1, flush=4'b0010
//   -> output sequence is A, bubble, C, D; B is never seen.
//   Bubble cycle: out_valid=0, out_data=0.
// - Flush on held full stage:
//   Chain full, out_ready=0, flush=4'b1000 -> next cycle out_valid=0,
//   occupancy=3, in_ready=1.
// - Counter saturation (CNT_W=4):
//   out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15.
//   stall_clr plus stall in the same cycle -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain with per-stage flush-to-bubble,
// occupancy count and a saturating output-stall counter.
module pipe_stage_chain #(
  parameter  int WIDTH = 274,
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic [DEPTH-1:0] flush,
  input  logic             stall_clr,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [DEPTH:0]   src_valid;
  logic [WIDTH-1:0] src_data [DEPTH+1];
  logic [CNT_W-1:0] stall_q, stall_d;

  // Ripple !valid[i] || rdy[i+1] written flat so no comb vector feeds itself.
  for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
    assign rdy[g] = out_ready | ~(&valid_q[DEPTH-1:g]);
  end

  // src_*[i] is whatever sits upstream of stage i; index DEPTH is the output.
  assign src_valid   = {valid_q, in_valid};
  assign src_data[0] = in_data;
  for (genvar g = 0; g < DEPTH; g++) begin : g_src
    assign src_data[g+1] = data_q[g];
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i]) begin
        valid_d[i] = src_valid[i];
        data_d[i]  = src_valid[i] ? src_data[i] : '0;
      end
      if (flush[i]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = '0;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_clr) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(valid_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      stall_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      stall_q <= stall_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = src_valid[DEPTH];
  assign out_data  = src_data[DEPTH];
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: reset, streaming, backpressure, flush,
// and stall-counter saturation on a narrow-counter second instance.
module tb_pipe_stage_chain;
  localparam int W = 274;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;
  logic [D-1:0] flush;
  logic         stall_clr;

  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [2:0]   occupancy;
  logic [15:0]  stall_cnt;

  logic         in_ready2, out_valid2;
  logic [W-1:0] out_data2;
  logic [2:0]   occupancy2;
  logic [3:0]   stall_cnt2;

  int checks = 0;
  int failures = 0;
  int idx, exp_next, n_items;
  logic acc_in;

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .flush(flush), .stall_clr(stall_clr),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
    .out_ready(out_ready), .flush(flush), .stall_clr(stall_clr),
    .occupancy(occupancy2), .stall_cnt(stall_cnt2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle of a source that holds its item until accepted; checks order of drained items.
  task automatic src_cycle(input logic ordy);
    in_valid  = (idx <= n_items);
    in_data   = W'(idx);
    out_ready = ordy;
    #1;
    acc_in = in_valid && in_ready;
    if (out_valid && out_ready) begin
      chk("bp_order", out_data, 300'(exp_next));
      exp_next++;
    end
    @(posedge clk);
    #1;
    if (acc_in) idx++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush = '0; stall_clr = 1'b0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_occ",       occupancy, 0);
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_stall",     stall_cnt, 0);
    rst = 1'b0;

    // Fill while stalled, then reset with traffic present
    in_valid = 1'b1; in_data = W'(8'hAA);
    tick(); tick(); tick();
    chk("fill_occ3", occupancy, 3);
    tick(); tick();
    chk("fill_stall1", stall_cnt, 1);
    out_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_occ",       occupancy, 0);
    chk("rstmid_in_ready",  in_ready, 1);
    chk("rstmid_stall",     stall_cnt, 0);
    chk("rstmid_out_data",  out_data, 0);
    tick();
    chk("rsthold_occ", occupancy, 0);
    rst = 1'b0; in_valid = 1'b1; in_data = W'(8'h77);
    tick();
    chk("postrst_occ", occupancy, 1);
    chk("postrst_out_valid", out_valid, 0);
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("postrst_out", out_data, 300'h77);
    tick();
    chk("postrst_empty", occupancy, 0);

    // Streaming 1..8: item k appears after edge k+3
    out_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      in_valid = (c <= 8);
      in_data  = W'(c);
      tick();
      if (c >= 4 && c <= 11) begin
        chk("stream_valid", out_valid, 1);
        chk("stream_data",  out_data, 300'(c - 3));
      end else begin
        chk("stream_idle_valid", out_valid, 0);
        chk("stream_idle_data",  out_data, 0);
      end
    end
    chk("stream_stall", stall_cnt, 0);

    // Full backpressure with 6 items
    idx = 1; exp_next = 1; n_items = 6;
    for (int c = 0; c < 4; c++) src_cycle(1'b0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_occ",      occupancy, 4);
    chk("bp_src_idx",  idx, 5);
    for (int c = 0; c < 4; c++) src_cycle(1'b0);
    chk("bp_stall_cnt", stall_cnt, 4);
    chk("bp_hold_data", out_data, 300'h1);
    for (int c = 0; c < 12; c++) src_cycle(1'b1);
    chk("bp_all_out",   exp_next, 7);
    chk("bp_stall_end", stall_cnt, 4);
    chk("bp_empty",     occupancy, 0);

    // Flush stage 1 as B would enter it: A, bubble, C, D
    out_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      in_valid = (c <= 4);
      in_data  = W'(9 + c);
      flush    = (c == 3) ? 4'b0010 : 4'b0000;
      tick();
      case (c)
        4: begin chk("fl_A_v", out_valid, 1); chk("fl_A_d", out_data, 300'hA); end
        5: begin chk("fl_bub_v", out_valid, 0); chk("fl_bub_d", out_data, 0); end
        6: begin chk("fl_C_v", out_valid, 1); chk("fl_C_d", out_data, 300'hC); end
        7: begin chk("fl_D_v", out_valid, 1); chk("fl_D_d", out_data, 300'hD); end
        8: chk("fl_end_v", out_valid, 0);
        default: ;
      endcase
    end
    flush = '0;

    // Flush of the held, full output stage
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_data = W'(8'h21 + c);
      tick();
    end
    chk("hf_full_ready", in_ready, 0);
    in_valid = 1'b0; flush = 4'b1000;
    tick();
    flush = '0;
    chk("hf_out_valid", out_valid, 0);
    chk("hf_out_data",  out_data, 0);
    chk("hf_occ",       occupancy, 3);
    chk("hf_in_ready",  in_ready, 1);
    out_ready = 1'b1;
    tick(); chk("hf_d22", out_data, 300'h22);
    tick(); chk("hf_d23", out_data, 300'h23);
    tick(); chk("hf_d24", out_data, 300'h24);
    tick(); chk("hf_empty", occupancy, 0);

    // Stall counter saturation
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(8'h55);
    for (int c = 0; c < 4; c++) tick();
    in_valid = 1'b0; stall_clr = 1'b1;
    tick();
    chk("sat_clr16", stall_cnt, 0);
    chk("sat_clr4",  stall_cnt2, 0);
    stall_clr = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    chk("sat_cnt4",  stall_cnt2, 15);
    chk("sat_cnt16", stall_cnt, 20);
    stall_clr = 1'b1;
    tick();
    chk("sat_clrwin4",  stall_cnt2, 0);
    chk("sat_clrwin16", stall_cnt, 0);
    stall_clr = 1'b0;
    tick();
    chk("sat_restart", stall_cnt2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
